// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor: digit-serial diff = a - b - bin, DIGIT bits per cycle, LSB first, one op in flight.
// Optional build macro SERSUB_OVF_EN adds a registered two's-complement overflow output (ovf).

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit subtracted per cycle with running borrow
// DONE  | result held on diff/bout until out_ready
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_subtractor: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             brw;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_nxt;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_res;
    logic             last_dig;
    logic             accept;
    int               base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)  state_nxt = S_RUN;
            S_RUN:   if (last_dig)  state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !rst;
        busy      = (state != S_IDLE);
        out_valid = (state == S_DONE);
    end

    assign accept = in_valid && in_ready;

    // Current digit slice; the partial result is merged into diff_sr so the
    // final digit can be written to diff on the same edge it is produced.
    always_comb begin
        base     = int'(cnt) * DIGIT;
        a_dig    = a_r[base +: DIGIT];
        b_dig    = b_r[base +: DIGIT];
        dig_res  = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, brw};
        diff_nxt = diff_sr;
        diff_nxt[base +: DIGIT] = dig_res[DIGIT-1:0];
        last_dig = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            brw     <= 1'b0;
            diff_sr <= '0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_r <= a;
                        b_r <= b;
                        brw <= bin;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    diff_sr <= diff_nxt;
                    brw     <= dig_res[DIGIT];
                    cnt     <= last_dig ? '0 : cnt + CW'(1);
                    if (last_dig) begin
                        diff <= diff_nxt;
                        bout <= dig_res[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == S_RUN && last_dig) begin
            ovf <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (diff_nxt[WIDTH-1] ^ a_r[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
// Bench for serial_subtractor: directed table + corner sequences on a DIGIT=4 instance,
// then scoreboarded random traffic with stalls on DIGIT=1/4/16 instances.
module tb_serial_subtractor;
    localparam int W  = 16;
    localparam int NV = 340;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        string        name;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_pass = 0;
    int   n_total = 0;
    bit   rand_go = 1'b0;
    int   rand_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        res_t r;
        logic [W:0] m;
        m    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        r.d  = m[W-1:0];
        r.bo = m[W];
        r.ov = (ma[W-1] ^ mb[W-1]) & (m[W-1] ^ ma[W-1]);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    // Directed instance
    logic         iv, ir, ov, orr, binv, bov, busy;
    logic [W-1:0] av, bv, dv;
`ifdef SERSUB_OVF_EN
    logic         ovf_d;
`endif
    res_t sb_q[$];

    serial_subtractor #(.WIDTH(W), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(iv), .in_ready(ir),
        .a(av), .b(bv), .bin(binv),
        .out_valid(ov), .out_ready(orr),
        .diff(dv), .bout(bov),
`ifdef SERSUB_OVF_EN
        .ovf(ovf_d),
`endif
        .busy(busy)
    );

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin,
                            input res_t e, input string name);
        int w = 0;
        @(negedge clk);
        av = ta; bv = tbv; binv = tbin; iv = 1'b1;
        while (!ir && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({name, " in_ready"}, 32'(ir), 32'd1);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0; av = ~ta; bv = ~tbv; binv = ~tbin;
    endtask

    task automatic wait_out(output int edges);
        edges = 1;
        while (!ov && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic finish_op(input string name);
        res_t e;
        orr = 1'b1;
        if (sb_q.size() == 0) begin
            check({name, " scoreboard"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({name, " out_valid"}, 32'(ov), 32'd1);
            check({name, " diff"}, 32'(dv), 32'(e.d));
            check({name, " bout"}, 32'(bov), 32'(e.bo));
`ifdef SERSUB_OVF_EN
            check({name, " ovf"}, 32'(ovf_d), 32'(e.ov));
`endif
        end
        @(negedge clk);
        orr = 1'b0;
    endtask

    task automatic do_op(input vec_t v);
        res_t e;
        int   edges;
        e.d = v.d; e.bo = v.bo; e.ov = v.ov;
        start_op(v.a, v.b, v.bin, e, v.name);
        wait_out(edges);
        check({v.name, " latency"}, 32'(edges), 32'd5);
        finish_op(v.name);
    endtask

    // Random instances, DIGIT = 1, 4, 16
    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        logic         iv_r, ir_r, ov_r, or_r, bin_r, bo_r, busy_r;
        logic [W-1:0] a_r, b_r, d_r;
`ifdef SERSUB_OVF_EN
        logic         ovf_r;
`endif
        res_t q[$];

        serial_subtractor #(.WIDTH(W), .DIGIT(DG)) u_r (
            .clk(clk), .rst(rst),
            .in_valid(iv_r), .in_ready(ir_r),
            .a(a_r), .b(b_r), .bin(bin_r),
            .out_valid(ov_r), .out_ready(or_r),
            .diff(d_r), .bout(bo_r),
`ifdef SERSUB_OVF_EN
            .ovf(ovf_r),
`endif
            .busy(busy_r)
        );

        initial begin : drv
            int w;
            iv_r = 1'b0; a_r = '0; b_r = '0; bin_r = 1'b0;
            wait (rand_go);
            for (int i = 0; i < NV; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(negedge clk);
                a_r = rnd_op(); b_r = rnd_op(); bin_r = 1'($urandom);
                iv_r = 1'b1;
                w = 0;
                while (!ir_r && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                check($sformatf("rand%0d accept", DG), 32'(ir_r), 32'd1);
                if (ir_r) q.push_back(model(a_r, b_r, bin_r));
                @(posedge clk);
                @(negedge clk);
                iv_r = 1'b0; a_r = W'($urandom); b_r = W'($urandom); bin_r = 1'($urandom);
            end
        end

        initial begin : mon
            res_t e;
            int   got;
            int   cyc;
            got = 0; cyc = 0;
            or_r = 1'b0;
            wait (rand_go);
            while (got < NV && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                or_r = 1'($urandom);
                if (ov_r && or_r) begin
                    if (q.size() == 0) begin
                        check($sformatf("rand%0d unexpected result", DG), 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("rand%0d diff", DG), 32'(d_r), 32'(e.d));
                        check($sformatf("rand%0d bout", DG), 32'(bo_r), 32'(e.bo));
`ifdef SERSUB_OVF_EN
                        check($sformatf("rand%0d ovf", DG), 32'(ovf_r), 32'(e.ov));
`endif
                    end
                    got++;
                end
            end
            check($sformatf("rand%0d result count", DG), 32'(got), 32'(NV));
            @(negedge clk);
            or_r = 1'b0;
            repeat (25) @(negedge clk);
            check($sformatf("rand%0d no extra result", DG), 32'(ov_r), 32'd0);
            check($sformatf("rand%0d idle", DG), 32'(busy_r), 32'd0);
            check($sformatf("rand%0d queue empty", DG), 32'(q.size()), 32'd0);
            rand_done++;
        end
    end

    vec_t vecs[8];

    initial begin
        res_t e;
        int   edges;
        int   budget;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "basic"};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "underflow"};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, "wrap bin"};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0, 1'b1, "neg ovf"};
        vecs[4] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, "small"};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "pos ovf"};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "all ones"};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h0E1E, 1'b0, 1'b0, "digit borrow"};

        rst = 1'b1; iv = 1'b0; orr = 1'b0; av = '0; bv = '0; binv = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(ov), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(ir), 32'd0);
        check("reset diff", 32'(dv), 32'd0);
        check("reset bout", 32'(bov), 32'd0);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 32'(ir), 32'd1);

        for (int i = 0; i < 8; i++) do_op(vecs[i]);

        // Result held in DONE while the consumer stalls; in_valid pulses are ignored
        e.d = 16'h4B4A; e.bo = 1'b0; e.ov = 1'b1;
        start_op(16'hA5A5, 16'h5A5A, 1'b1, e, "hold");
        wait_out(edges);
        check("hold latency", 32'(edges), 32'd5);
        for (int i = 0; i < 10; i++) begin
            iv = 1'(i % 2); av = W'($urandom); bv = W'($urandom);
            check("hold out_valid", 32'(ov), 32'd1);
            check("hold diff", 32'(dv), 32'h4B4A);
            check("hold bout", 32'(bov), 32'd0);
            check("hold in_ready", 32'(ir), 32'd0);
            @(negedge clk);
        end
        iv = 1'b0;
        finish_op("hold");
        check("after hs out_valid", 32'(ov), 32'd0);
        check("after hs busy", 32'(busy), 32'd0);
        check("after hs in_ready", 32'(ir), 32'd1);
        check("after hs diff kept", 32'(dv), 32'h4B4A);
        repeat (3) @(negedge clk);
        check("no second op", 32'(busy), 32'd0);

        // Reset during the second RUN cycle drops the operation
        e.d = 16'h1000; e.bo = 1'b0; e.ov = 1'b0;
        start_op(16'h1234, 16'h0234, 1'b0, e, "rst-run");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst in_ready low", 32'(ir), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst out_valid", 32'(ov), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(ir), 32'd1);
        check("rst diff cleared", 32'(dv), 32'd0);
        sb_q.delete();
        do_op('{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, "after rst"});
        check("directed queue empty", 32'(sb_q.size()), 32'd0);

        rand_go = 1'b1;
        budget = 0;
        while (rand_done < 3 && budget < 50000) begin
            @(negedge clk);
            budget++;
        end
        check("random phase complete", 32'(rand_done), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
